// File: rtl/proc_pkg.sv
// proc_pkg: shared processor opcodes and load/store unit state encoding
package proc_pkg;
  localparam logic [3:0] OP_LW = 4'b0111;
  localparam logic [3:0] OP_SW = 4'b1000;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_ERR} lsu_state_t;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
endpackage

// File: rtl/lsu_timeout_cnt.sv
// lsu_timeout_cnt: counts memory wait cycles and flags the last allowed one
module lsu_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  // wait-cycle counter, held at zero whenever cleared
  always_ff @(posedge clk)
    if (reset || clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 1'b1;
  assign expired = r_cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes lw/sw against data memory with range check and ack timeout
module load_store_unit
  import proc_pkg::*;
#(
  parameter int DMEM_AW = 9,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_opcode,
  input  logic [15:0]        req_addr,
  input  logic [15:0]        req_wdata,
  input  logic [3:0]         req_dest,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [15:0]        mem_wdata,
  input  logic               mem_ack,
  input  logic [15:0]        mem_rdata,
  output logic               wb_valid,
  output logic [3:0]         wb_dest,
  output logic [15:0]        wb_data,
  output logic               busy,
  output logic               err
);
  lsu_state_t r_state, w_next;
  logic [3:0] r_op, r_dest, r_wb_dest;
  logic [DMEM_AW-1:0] r_addr;
  logic [15:0] r_wdata, r_wb_data;
  logic w_accept, w_oor, w_expired;
  assign w_accept = req_valid && req_ready;
  assign w_oor = (req_addr >> DMEM_AW) != 16'd0;
  lsu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clear(r_state != S_ACCESS),
    .enable(!mem_ack),
    .expired(w_expired)
  );
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: ack beats expiry, WB and ERR each last one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_accept && is_mem_op(req_opcode) ? (w_oor ? S_ERR : S_ACCESS) : S_IDLE;
      S_ACCESS: w_next = mem_ack ? (r_op == OP_LW ? S_WB : S_IDLE) : (w_expired ? S_ERR : S_ACCESS);
      default:  w_next = S_IDLE;
    endcase
  end
  // request capture on acceptance and load data capture on ack
  always_ff @(posedge clk)
    if (reset) begin
      r_op <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_dest <= '0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_op <= req_opcode;
        r_addr <= req_addr[DMEM_AW-1:0];
        r_wdata <= req_wdata;
        r_dest <= req_dest;
      end
      if (r_state == S_ACCESS && mem_ack && r_op == OP_LW) begin
        r_wb_data <= mem_rdata;
        r_wb_dest <= r_dest;
      end
    end
  assign req_ready = r_state == S_IDLE;
  assign busy = r_state != S_IDLE;
  assign mem_req = r_state == S_ACCESS;
  assign mem_we = r_op == OP_SW;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign wb_valid = r_state == S_WB;
  assign wb_dest = r_wb_dest;
  assign wb_data = r_wb_data;
  assign err = r_state == S_ERR;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a transaction-level model
module tb_load_store_unit;
  localparam int TMO = 15;
  localparam logic [3:0] LW = 4'b0111, SW = 4'b1000;
  logic clk = 0, reset = 1, req_valid = 0, req_ready, mem_req, mem_we, mem_ack = 0;
  logic wb_valid, busy, err;
  logic [3:0] req_opcode = 0, req_dest = 0, wb_dest;
  logic [15:0] req_addr = 0, req_wdata = 0, mem_wdata, mem_rdata = 0, wb_data;
  logic [8:0] mem_addr;
  int checks = 0, failures = 0;
  int o_mreq, o_err, o_wb, o_ready;
  logic o_we, o_stable, o_busy_bad, noise;
  logic [8:0] o_addr;
  logic [15:0] o_wdata, o_wbdata, last_data;
  logic [3:0] o_wbdest, last_dest;

  load_store_unit #(.DMEM_AW(9), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata), .req_dest(req_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_data(wb_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // transaction outcome from the rules: counts of mem_req/err/wb cycles and cycles until ready
  function automatic void model(input logic [3:0] op, input logic [15:0] addr, input int d,
                                output int mreq, output int e, output int wb, output int rdy);
    int lw;
    lw = (op == LW) ? 1 : 0;
    if (op != LW && op != SW) begin mreq = 0; e = 0; wb = 0; rdy = 1; end
    else if (addr >= 16'd512) begin mreq = 0; e = 1; wb = 0; rdy = 2; end
    else if (d < TMO) begin mreq = d + 1; e = 0; wb = lw; rdy = d + 2 + lw; end
    else begin mreq = TMO; e = 1; wb = 0; rdy = TMO + 2; end
  endfunction

  // drive one request, act as memory acking on the (d+1)th mem_req cycle, record what was seen
  task automatic do_txn(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [3:0] dest, input int d, input logic [15:0] rdata);
    int w;
    o_mreq = 0; o_err = 0; o_wb = 0; o_ready = 0; o_stable = 1;
    o_we = 0; o_addr = 0; o_wdata = 0; o_wbdata = 0; o_wbdest = 0;
    w = 0;
    while (!req_ready && w < 40) begin @(negedge clk); w++; end
    req_valid = 1; req_opcode = op; req_addr = addr; req_wdata = wdata; req_dest = dest;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_opcode = 4'($urandom); req_addr = 16'($urandom);
    req_wdata = 16'($urandom); req_dest = 4'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== !req_ready) o_busy_bad = 1;
      if (req_ready) begin o_ready = k; break; end
      if (mem_req) begin
        o_mreq++;
        if (o_mreq == 1) begin o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; end
        else if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wdata) o_stable = 0;
      end
      if (err) o_err++;
      if (wb_valid) begin o_wb++; o_wbdata = wb_data; o_wbdest = wb_dest; end
      mem_ack = mem_req ? (o_mreq == d + 1) : (noise && ($urandom % 2 == 1));
      mem_rdata = (mem_req && o_mreq == d + 1) ? rdata : 16'($urandom);
    end
    mem_ack = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_req, mem_we, wb_valid, err, busy} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {mem_req, mem_we, wb_valid, err, busy}); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if ({mem_addr, mem_wdata, wb_dest, wb_data} !== 45'b0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, wb_dest, wb_data}); end
    reset = 0;
    last_data = 0; last_dest = 0;
  endtask

  task automatic test_lw;
    do_txn(LW, 16'h0005, 16'h7777, 4'd3, 0, 16'hBEEF);
    checks++; if (o_mreq !== 1) begin failures++; $display("FAIL lw_mreq got=%0d exp=1", o_mreq); end
    checks++; if (o_addr !== 9'd5 || o_we !== 1'b0) begin failures++; $display("FAIL lw_addr_we got=%h/%b exp=005/0", o_addr, o_we); end
    checks++; if (o_wb !== 1 || o_wbdest !== 4'd3 || o_wbdata !== 16'hBEEF) begin failures++; $display("FAIL lw_wb got=%0d/%h/%h exp=1/3/beef", o_wb, o_wbdest, o_wbdata); end
    checks++; if (o_ready !== 3 || o_err !== 0) begin failures++; $display("FAIL lw_latency got=%0d err=%0d exp=3 err=0", o_ready, o_err); end
    checks++; if (wb_data !== 16'hBEEF || wb_dest !== 4'd3) begin failures++; $display("FAIL lw_hold got=%h/%h exp=beef/3", wb_data, wb_dest); end
    last_data = 16'hBEEF; last_dest = 4'd3;
  endtask

  task automatic test_sw;
    do_txn(SW, 16'h01FF, 16'h1234, 4'd9, 4, 16'h0);
    checks++; if (o_mreq !== 5 || o_stable !== 1'b1) begin failures++; $display("FAIL sw_hold_req got=%0d stable=%b exp=5 stable=1", o_mreq, o_stable); end
    checks++; if (o_we !== 1'b1 || o_addr !== 9'h1FF || o_wdata !== 16'h1234) begin failures++; $display("FAIL sw_bus got=%b/%h/%h exp=1/1ff/1234", o_we, o_addr, o_wdata); end
    checks++; if (o_wb !== 0 || o_err !== 0 || o_ready !== 6) begin failures++; $display("FAIL sw_done got=wb%0d err%0d rdy%0d exp=wb0 err0 rdy6", o_wb, o_err, o_ready); end
  endtask

  task automatic test_range;
    do_txn(LW, 16'h0200, 16'h0, 4'd1, 0, 16'h0);
    checks++; if (o_mreq !== 0 || o_wb !== 0) begin failures++; $display("FAIL range_nomem got=mreq%0d wb%0d exp=0/0", o_mreq, o_wb); end
    checks++; if (o_err !== 1 || o_ready !== 2) begin failures++; $display("FAIL range_err got=err%0d rdy%0d exp=err1 rdy2", o_err, o_ready); end
  endtask

  task automatic test_timeout;
    do_txn(SW, 16'h0010, 16'hAAAA, 4'd0, 1000, 16'h0);
    checks++; if (o_mreq !== TMO || o_err !== 1 || o_wb !== 0) begin failures++; $display("FAIL tmo_abort got=mreq%0d err%0d wb%0d exp=15/1/0", o_mreq, o_err, o_wb); end
    checks++; if (o_ready !== TMO + 2) begin failures++; $display("FAIL tmo_ready got=%0d exp=%0d", o_ready, TMO + 2); end
    do_txn(SW, 16'h0011, 16'hBBBB, 4'd0, TMO - 1, 16'h0);
    checks++; if (o_mreq !== TMO || o_err !== 0 || o_ready !== TMO + 1) begin failures++; $display("FAIL tmo_ack_edge_sw got=mreq%0d err%0d rdy%0d exp=15/0/16", o_mreq, o_err, o_ready); end
    do_txn(LW, 16'h0012, 16'h0, 4'd6, TMO - 1, 16'h5A5A);
    checks++; if (o_err !== 0 || o_wb !== 1 || o_wbdata !== 16'h5A5A) begin failures++; $display("FAIL tmo_ack_edge_lw got=err%0d wb%0d data%h exp=0/1/5a5a", o_err, o_wb, o_wbdata); end
    last_data = 16'h5A5A; last_dest = 4'd6;
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1; req_opcode = LW; req_addr = 16'h0007; req_dest = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_start got=%b exp=1", mem_req); end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b%b%b%b exp=0100", mem_req, req_ready, busy, err); end
    reset = 0;
    last_data = 0; last_dest = 0;
    o_wb = 0; o_err = 0;
    mem_ack = 1; mem_rdata = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      if (wb_valid) o_wb++;
      if (err) o_err++;
    end
    mem_ack = 0;
    checks++; if (o_wb !== 0 || o_err !== 0) begin failures++; $display("FAIL rst_mid_late_ack got=wb%0d err%0d exp=0/0", o_wb, o_err); end
    checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL rst_mid_wbdata got=%h exp=0000", wb_data); end
  endtask

  task automatic test_nonmem;
    do_txn(4'b0000, 16'h0003, 16'h0, 4'd5, 0, 16'h0);
    checks++; if (o_mreq !== 0 || o_wb !== 0 || o_err !== 0) begin failures++; $display("FAIL nonmem_effect got=mreq%0d wb%0d err%0d exp=0/0/0", o_mreq, o_wb, o_err); end
    checks++; if (o_ready !== 1) begin failures++; $display("FAIL nonmem_ready got=%0d exp=1", o_ready); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      do_txn(LW, 16'(i * 3), 16'h0, 4'(i + 10), 0, 16'(16'hC000 + i));
      checks++; if (o_ready !== 3 || o_wbdata !== 16'(16'hC000 + i) || o_wbdest !== 4'(i + 10)) begin failures++; $display("FAIL b2b_%0d got=rdy%0d %h/%h", i, o_ready, o_wbdata, o_wbdest); end
    end
    last_data = 16'hC002; last_dest = 4'd12;
  endtask

  task automatic test_random;
    logic [3:0] op, dest;
    logic [15:0] addr, wdata, rdata;
    int d, em, ee, ew, er, sel;
    noise = 1; o_busy_bad = 0;
    for (int t = 0; t < 60; t++) begin
      sel = $urandom % 5;
      op = sel < 2 ? LW : sel < 4 ? SW : 4'($urandom);
      addr = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom % 512);
      wdata = 16'($urandom); dest = 4'($urandom); rdata = 16'($urandom);
      d = $urandom % 20;
      do_txn(op, addr, wdata, dest, d, rdata);
      model(op, addr, d, em, ee, ew, er);
      checks++; if (o_mreq !== em || o_err !== ee || o_wb !== ew || o_ready !== er) begin failures++; $display("FAIL rnd%0d_flow op=%h a=%h d=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", t, op, addr, d, o_mreq, o_err, o_wb, o_ready, em, ee, ew, er); end
      if (em > 0) begin
        checks++; if (o_addr !== addr[8:0] || o_we !== (op == SW) || o_stable !== 1'b1 || (op == SW && o_wdata !== wdata)) begin failures++; $display("FAIL rnd%0d_bus got=%h/%b/%h stable=%b exp=%h/%b/%h", t, o_addr, o_we, o_wdata, o_stable, addr[8:0], op == SW, wdata); end
      end
      if (ew == 1) begin
        checks++; if (o_wbdata !== rdata || o_wbdest !== dest) begin failures++; $display("FAIL rnd%0d_wb got=%h/%h exp=%h/%h", t, o_wbdata, o_wbdest, rdata, dest); end
        last_data = rdata; last_dest = dest;
      end
      checks++; if (wb_data !== last_data || wb_dest !== last_dest) begin failures++; $display("FAIL rnd%0d_hold got=%h/%h exp=%h/%h", t, wb_data, wb_dest, last_data, last_dest); end
    end
    checks++; if (o_busy_bad !== 1'b0) begin failures++; $display("FAIL busy_vs_ready got=%b exp=0", o_busy_bad); end
    noise = 0;
  endtask

  initial begin
    noise = 0; o_busy_bad = 0;
    test_reset;
    test_lw;
    test_sw;
    test_range;
    test_timeout;
    test_nonmem;
    test_back_to_back;
    test_reset_mid_access;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
